vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_timing_gen_if.sv | 40 ++++
 rtl/vga_axis_counter.sv | 71 +++++++
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants for the 640x480@60 video path. The timing generator,
// the audio block and the render blocks all import this package, so the
// default mode is defined in exactly one place.
//
// Contents:
//   POS_W / FRAME_CNT_W       : widths of the position and frame counters
//   MAX_TOTAL                 : largest legal H_TOTAL / V_TOTAL (10-bit counters)
//   DEF_H_* / DEF_V_*         : default 640x480@60 porch/sync/active values
//   H_TOTAL / V_TOTAL         : derived default line and frame lengths
//   axis_total()              : sums the four segments of one axis
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int POS_W       = 10;
    localparam int FRAME_CNT_W = 16;
    localparam int MAX_TOTAL   = 1 << POS_W;

    typedef logic [POS_W-1:0]       pos_t;
    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    function automatic int axis_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction

    localparam int H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle of the timing outputs produced by vga_timing_gen.
//
// Signals:
//   hpos, vpos    : current pixel column / line
//   hsync, vsync  : active-low sync pulses
//   display_on    : pixel is inside the visible area
//   line_start    : one-clock pulse at hpos==0
//   frame_start   : one-clock pulse at (0,0)
//   vblank_tick   : one-clock pulse at (0,V_ACTIVE)
//   frame_cnt     : frame counter (zero unless VGA_FRAME_CNT_EN is defined)
// Modports:
//   master : the timing generator (drives everything)
//   slave  : consumers (render, audio, testbench)
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    pos_t       hpos;
    pos_t       vpos;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       line_start;
    logic       frame_start;
    logic       vblank_tick;
    frame_cnt_t frame_cnt;

    modport master (
        output hpos, vpos, hsync, vsync, display_on,
               line_start, frame_start, vblank_tick, frame_cnt
    );

    modport slave (
        input  hpos, vpos, hsync, vsync, display_on,
               line_start, frame_start, vblank_tick, frame_cnt
    );

endinterface

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One axis of the raster: a wrap counter 0..TOTAL-1 plus decode of the sync
// window and active region. Used once for the horizontal axis (en tied high)
// and once for the vertical axis (en = horizontal wrap carry).
//
// Ports:
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   en           : advance the counter this clock
//   pos          : registered position
//   pos_next     : position after this clock edge (combinational)
//   wrap         : carry out, high when the counter goes TOTAL-1 -> 0 this clock
//   sync_n       : registered active-low sync, decoded from pos_next so it is
//                  aligned with pos
//   active_next  : pos_next lies inside the active region (combinational)
//
// Reset parks the counter on TOTAL-1 so the first edge after release wraps to
// 0 and raises the carry, which is what makes the first visible state (0,0).
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output pos_t pos,
    output pos_t pos_next,
    output logic wrap,
    output logic sync_n,
    output logic active_next
);

    localparam int   TOTAL      = axis_total(ACTIVE, FRONT, SYNC, BACK);
    localparam pos_t LAST       = pos_t'(TOTAL - 1);
    localparam pos_t ACTIVE_LIM = pos_t'(ACTIVE);
    localparam pos_t SYNC_FIRST = pos_t'(ACTIVE + FRONT);
    localparam pos_t SYNC_LAST  = pos_t'(ACTIVE + FRONT + SYNC - 1);

    pos_t pos_reg;
    logic sync_n_reg;
    logic sync_n_next;

    always_comb begin
        wrap        = en && (pos_reg == LAST);
        pos_next    = pos_reg;
        if (en) begin
            pos_next = wrap ? '0 : pos_reg + 1'b1;
        end
        sync_n_next = !((pos_next >= SYNC_FIRST) && (pos_next <= SYNC_LAST));
        active_next = (pos_next < ACTIVE_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_reg    <= LAST;
            sync_n_reg <= 1'b1;
        end else begin
            pos_reg    <= pos_next;
            sync_n_reg <= sync_n_next;
        end
    end

    assign pos    = pos_reg;
    assign sync_n = sync_n_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator (640x480@60 by default). Every output is a flop
// loaded from the next-state counter values, so sync, blanking and pulse
// outputs line up with hpos/vpos on the same clock and never glitch.
//
// Ports:
//   clk   : pixel clock (25.175 MHz nominal)
//   rst_n : asynchronous active-low reset; holds hpos=H_TOTAL-1,
//           vpos=V_TOTAL-1, syncs high, display_on and pulses low
//   vga   : vga_timing_gen_if.master carrying all timing outputs
//
// Optional feature: define VGA_FRAME_CNT_EN to build the 16-bit frame counter.
// Without it frame_cnt is a constant 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_timing_gen_if.master   vga
);

    localparam int   H_TOTAL_CFG = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int   V_TOTAL_CFG = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam pos_t VBLANK_LINE = pos_t'(V_ACTIVE);

    // The position counters are POS_W bits wide; refuse any mode that would
    // not fit rather than silently wrapping early.
    if (H_TOTAL_CFG > MAX_TOTAL) begin : g_h_total_too_big
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL_CFG > MAX_TOTAL) begin : g_v_total_too_big
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end

    pos_t h_pos;
    pos_t h_pos_next;
    pos_t v_pos;
    pos_t v_pos_next;
    logic h_wrap;
    logic v_wrap;
    logic h_sync_n;
    logic v_sync_n;
    logic h_active_next;
    logic v_active_next;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (1'b1),
        .pos         (h_pos),
        .pos_next    (h_pos_next),
        .wrap        (h_wrap),
        .sync_n      (h_sync_n),
        .active_next (h_active_next)
    );

    // The vertical axis only moves on the clock the horizontal axis wraps.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (h_wrap),
        .pos         (v_pos),
        .pos_next    (v_pos_next),
        .wrap        (v_wrap),
        .sync_n      (v_sync_n),
        .active_next (v_active_next)
    );

    // Pulse decode from next-state values. h_wrap means the next hpos is 0,
    // and v_wrap (which already includes h_wrap) means the next position is
    // (0,0), so both pulses come straight from the counter carries.
    logic display_on_reg;
    logic line_start_reg;
    logic frame_start_reg;
    logic vblank_tick_reg;
    logic vblank_next;

    always_comb begin
        vblank_next = h_wrap && (v_pos_next == VBLANK_LINE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_on_reg  <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            vblank_tick_reg <= 1'b0;
        end else begin
            display_on_reg  <= h_active_next && v_active_next;
            line_start_reg  <= h_wrap;
            frame_start_reg <= v_wrap;
            vblank_tick_reg <= vblank_next;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Counts on the same edge that raises vblank_tick, so frame_cnt already
    // shows the new frame number while the tick is high.
    frame_cnt_t frame_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (vblank_next) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
    end

    assign vga.frame_cnt = frame_cnt_reg;
`else
    assign vga.frame_cnt = '0;
`endif

    assign vga.hpos        = h_pos;
    assign vga.vpos        = v_pos;
    assign vga.hsync       = h_sync_n;
    assign vga.vsync       = v_sync_n;
    assign vga.display_on  = display_on_reg;
    assign vga.line_start  = line_start_reg;
    assign vga.frame_start = frame_start_reg;
    assign vga.vblank_tick = vblank_tick_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Two generators share clk/rst_n: "dut" uses the default 640x480 timing and is
// used for reset and line-level checks; "dut_s" uses a tiny 15x13 raster so
// whole frames fit in a short run.
// Small raster: H 8/2/3/2 (hsync low at hpos 10..12), V 6/2/2/3 (vsync low at
// vpos 8..9), 195 clocks per frame, vblank_tick at (0,6) = cycle 90 of a frame.
// cyc counts clocks since the first edge after reset release (that edge = 0).
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2, S_HT = 15;
    localparam int S_VA = 6, S_VF = 2, S_VS = 2, S_VB = 3, S_VT = 13;
    localparam int S_FT = S_HT * S_VT;
    localparam int S_TICK = S_VA * S_HT;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    vga_timing_gen_if vif ();
    vga_timing_gen_if sif ();

    vga_timing_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vif)
    );

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_ACTIVE (S_VA), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (sif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected small-raster frame counter after cycle c (ticks at c%195==90).
    function automatic logic [15:0] exp_fc_s(input int c);
`ifdef VGA_FRAME_CNT_EN
        if (c < S_TICK) return 16'd0;
        return 16'((c - S_TICK) / S_FT + 1);
`else
        return 16'd0 + 16'(c & 0);
`endif
    endfunction

    task automatic test_reset();
        logic [15:0] act [12];
        logic [15:0] req [12];
        string       nm  [12];
        #2 rst_n = 1'b0;
        #1;
        nm  = '{"rst_hpos", "rst_vpos", "rst_hsync", "rst_vsync", "rst_disp", "rst_ls",
                "rst_fs", "rst_vbt", "rst_fcnt", "rst_s_hpos", "rst_s_vpos", "rst_s_disp"};
        act = '{16'(vif.hpos), 16'(vif.vpos), 16'(vif.hsync), 16'(vif.vsync),
                16'(vif.display_on), 16'(vif.line_start), 16'(vif.frame_start),
                16'(vif.vblank_tick), vif.frame_cnt, 16'(sif.hpos), 16'(sif.vpos),
                16'(sif.display_on)};
        req = '{16'd799, 16'd524, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                16'd14, 16'd12, 16'd0};
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (act[i] !== req[i]) begin
                errors++;
                $display("FAIL %s got %0d expected %0d", nm[i], act[i], req[i]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (vif.hpos !== 10'd799 || vif.vpos !== 10'd524) begin
            errors++;
            $display("FAIL rst_hold got %0d/%0d expected 799/524", vif.hpos, vif.vpos);
        end
    endtask

    task automatic test_first_edge();
        logic [15:0] act [12];
        logic [15:0] req [12];
        string       nm  [12];
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = -1;
        step();
        nm  = '{"fe_hpos", "fe_vpos", "fe_fs", "fe_ls", "fe_disp", "fe_hsync", "fe_vsync",
                "fe_vbt", "fe_s_hpos", "fe_s_vpos", "fe_s_fs", "fe_s_disp"};
        act = '{16'(vif.hpos), 16'(vif.vpos), 16'(vif.frame_start), 16'(vif.line_start),
                16'(vif.display_on), 16'(vif.hsync), 16'(vif.vsync), 16'(vif.vblank_tick),
                16'(sif.hpos), 16'(sif.vpos), 16'(sif.frame_start), 16'(sif.display_on)};
        req = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0,
                16'd0, 16'd0, 16'd1, 16'd1};
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (act[i] !== req[i]) begin
                errors++;
                $display("FAIL %s got %0d expected %0d", nm[i], act[i], req[i]);
            end
        end
    endtask

    // Two default-timing lines, every clock checked against the raster formula.
    task automatic test_line();
        int          low_cnt   = 0;
        int          first_low = -1;
        int          ls_cnt    = 0;
        int          disp_fall = -1;
        logic        prev_disp = 1'b1;
        logic [9:0]  eh, ev;
        logic        ehs, edisp, els;
        repeat (2 * 800) begin
            step();
            eh    = 10'(cyc % 800);
            ev    = 10'(cyc / 800);
            ehs   = !(eh >= 10'd656 && eh <= 10'd751);
            edisp = (eh < 10'd640) && (ev < 10'd480);
            els   = (eh == 10'd0);
            checks++;
            if (vif.hpos !== eh) begin
                errors++;
                $display("FAIL line_hpos cyc=%0d got %0d expected %0d", cyc, vif.hpos, eh);
            end
            checks++;
            if (vif.vpos !== ev) begin
                errors++;
                $display("FAIL line_vpos cyc=%0d got %0d expected %0d", cyc, vif.vpos, ev);
            end
            checks++;
            if (vif.hsync !== ehs) begin
                errors++;
                $display("FAIL line_hsync hpos=%0d got %b expected %b", eh, vif.hsync, ehs);
            end
            checks++;
            if (vif.display_on !== edisp) begin
                errors++;
                $display("FAIL line_disp hpos=%0d got %b expected %b", eh, vif.display_on, edisp);
            end
            checks++;
            if (vif.line_start !== els) begin
                errors++;
                $display("FAIL line_start hpos=%0d got %b expected %b", eh, vif.line_start, els);
            end
            if (cyc < 800 && vif.hsync === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = cyc;
            end
            if (vif.line_start === 1'b1) ls_cnt++;
            if (cyc < 800 && prev_disp === 1'b1 && vif.display_on === 1'b0 && disp_fall < 0)
                disp_fall = cyc;
            prev_disp = vif.display_on;
        end
        checks++;
        if (low_cnt !== 96) begin
            errors++;
            $display("FAIL hsync_width got %0d expected 96", low_cnt);
        end
        checks++;
        if (first_low !== 656) begin
            errors++;
            $display("FAIL hsync_start got %0d expected 656", first_low);
        end
        checks++;
        if (ls_cnt !== 2) begin
            errors++;
            $display("FAIL line_start_count got %0d expected 2", ls_cnt);
        end
        checks++;
        if (disp_fall !== 640) begin
            errors++;
            $display("FAIL disp_fall got %0d expected 640", disp_fall);
        end
    endtask

    // Three full small-raster frames: vsync window, pulses, frame counter.
    task automatic test_frame();
        int          tick_cnt = 0;
        int          fs_cnt   = 0;
        int          last_fs  = -1;
        logic [9:0]  eh, ev;
        logic        ehs, evs, edisp, efs, evbt;
        logic [15:0] efc;
        repeat (3 * S_FT) begin
            step();
            eh    = 10'(cyc % S_HT);
            ev    = 10'((cyc / S_HT) % S_VT);
            ehs   = !(eh >= 10'd10 && eh <= 10'd12);
            evs   = !(ev >= 10'd8 && ev <= 10'd9);
            edisp = (eh < 10'd8) && (ev < 10'd6);
            efs   = (eh == 10'd0) && (ev == 10'd0);
            evbt  = (eh == 10'd0) && (ev == 10'd6);
            efc   = exp_fc_s(cyc);
            checks++;
            if (sif.hpos !== eh || sif.vpos !== ev) begin
                errors++;
                $display("FAIL frame_pos cyc=%0d got %0d,%0d expected %0d,%0d",
                         cyc, sif.hpos, sif.vpos, eh, ev);
            end
            checks++;
            if (sif.hsync !== ehs || sif.vsync !== evs) begin
                errors++;
                $display("FAIL frame_sync at %0d,%0d got h%b v%b expected h%b v%b",
                         eh, ev, sif.hsync, sif.vsync, ehs, evs);
            end
            checks++;
            if (sif.display_on !== edisp) begin
                errors++;
                $display("FAIL frame_disp at %0d,%0d got %b expected %b",
                         eh, ev, sif.display_on, edisp);
            end
            checks++;
            if (sif.frame_start !== efs || sif.vblank_tick !== evbt) begin
                errors++;
                $display("FAIL frame_pulses at %0d,%0d got fs%b vbt%b expected fs%b vbt%b",
                         eh, ev, sif.frame_start, sif.vblank_tick, efs, evbt);
            end
            checks++;
            if (sif.frame_cnt !== efc || vif.frame_cnt !== 16'd0) begin
                errors++;
                $display("FAIL frame_cnt cyc=%0d got %0d/%0d expected %0d/0",
                         cyc, sif.frame_cnt, vif.frame_cnt, efc);
            end
            if (sif.vblank_tick === 1'b1) tick_cnt++;
            if (sif.frame_start === 1'b1) begin
                fs_cnt++;
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs !== S_FT) begin
                        errors++;
                        $display("FAIL frame_period got %0d expected %0d", cyc - last_fs, S_FT);
                    end
                end
                last_fs = cyc;
            end
        end
        checks++;
        if (tick_cnt !== 3 || fs_cnt !== 3) begin
            errors++;
            $display("FAIL frame_counts got ticks=%0d starts=%0d expected 3/3", tick_cnt, fs_cnt);
        end
    endtask

    // Reset dropped between edges mid-frame takes effect without a clock.
    task automatic test_async_reset();
        int guard = 0;
        while (!(sif.hpos === 10'd5 && sif.vpos === 10'd3) && guard < 2 * S_FT) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 2 * S_FT) begin
            errors++;
            $display("FAIL ar_wait got timeout expected position 5,3");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (vif.hpos !== 10'd799 || vif.vpos !== 10'd524 || vif.hsync !== 1'b1 ||
            vif.vsync !== 1'b1 || vif.display_on !== 1'b0 || vif.line_start !== 1'b0) begin
            errors++;
            $display("FAIL ar_default got %0d/%0d h%b v%b d%b ls%b expected 799/524 h1 v1 d0 ls0",
                     vif.hpos, vif.vpos, vif.hsync, vif.vsync, vif.display_on, vif.line_start);
        end
        checks++;
        if (sif.hpos !== 10'd14 || sif.vpos !== 10'd12 || sif.display_on !== 1'b0 ||
            sif.frame_start !== 1'b0 || sif.vblank_tick !== 1'b0 || sif.frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL ar_small got %0d/%0d d%b fs%b vbt%b fc%0d expected 14/12 d0 fs0 vbt0 fc0",
                     sif.hpos, sif.vpos, sif.display_on, sif.frame_start,
                     sif.vblank_tick, sif.frame_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = -1;
        step();
        checks++;
        if (sif.hpos !== 10'd0 || sif.vpos !== 10'd0 || sif.frame_start !== 1'b1 ||
            vif.hpos !== 10'd0 || vif.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL ar_restart got s%0d/%0d fs%b d%0d fs%b expected 0/0 fs1 0 fs1",
                     sif.hpos, sif.vpos, sif.frame_start, vif.hpos, vif.frame_start);
        end
    endtask

    task automatic test_frame_cnt();
`ifdef VGA_FRAME_CNT_EN
        while (cyc < S_TICK + 1) step();
        checks++;
        if (sif.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL fcnt_first got %0d expected 1", sif.frame_cnt);
        end
        force dut_s.frame_cnt_reg = 16'hFFFF;
        step();
        release dut_s.frame_cnt_reg;
        #0;
        checks++;
        if (sif.frame_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL fcnt_forced got %h expected ffff", sif.frame_cnt);
        end
        while (cyc < S_TICK + S_FT + 1) step();
        checks++;
        if (sif.frame_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL fcnt_wrap got %h expected 0000", sif.frame_cnt);
        end
`else
        int tick_cnt = 0;
        int nonzero  = 0;
        repeat (3 * S_FT) begin
            step();
            if (sif.vblank_tick === 1'b1) tick_cnt++;
            if (sif.frame_cnt !== 16'd0 || vif.frame_cnt !== 16'd0) nonzero++;
        end
        checks++;
        if (nonzero !== 0 || tick_cnt !== 3) begin
            errors++;
            $display("FAIL fcnt_tied got nonzero=%0d ticks=%0d expected 0/3", nonzero, tick_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_line();
        test_frame();
        test_async_reset();
        test_frame_cnt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
